// File: rtl/sine_voice_scheduler.sv
`timescale 1ns/1ps
// sine_voice_scheduler
// Shares one quarter-sine ROM between NVOICES phase accumulators and emits
// one mixed sample per audio frame (frame = rising edge of lrclk).
//
// Ports:
//   clk        system clock (only clock)
//   resetn     synchronous active-low reset
//   lrclk      asynchronous frame clock, synchronised internally
//   cfg_we     voice configuration write strobe
//   cfg_addr   voice index for the write
//   cfg_freq   phase increment for the addressed voice
//   cfg_en     enable for the addressed voice
//   out        mixed signed sample, held between frames
//   out_valid  one-cycle pulse when out updates
//   busy       high while a frame is being computed
//   overrun    sticky: frame start arrived while busy
//
// Build option: define SINESCHED_SATURATE_EN to output the clamped raw sum
// instead of the sum divided by NVOICES.
module sine_voice_scheduler #(
  parameter int BITSIZE   = 24,
  parameter int TABLESIZE = 9,
  parameter int PHASESIZE = 16,
  parameter int NVOICES   = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         lrclk,
  input  logic                         cfg_we,
  input  logic [$clog2(NVOICES)-1:0]   cfg_addr,
  input  logic [PHASESIZE-1:0]         cfg_freq,
  input  logic                         cfg_en,
  output logic [BITSIZE-1:0]           out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);
  localparam int VW    = $clog2(NVOICES);
  localparam int ACCW  = BITSIZE + VW;
  localparam int DEPTH = 1 << TABLESIZE;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  // Quarter-sine entry i = round((2^(BITSIZE-1)-1) * sin(pi/2 * (i+0.5)/DEPTH)),
  // evaluated at elaboration with a Q30 Taylor series so the ROM contents
  // need no external file.
  function automatic logic [BITSIZE-1:0] sin_entry(input int i);
    longint x, term, sum, amp;
    x    = (64'sd3373259426 * longint'(2 * i + 1)) >>> (TABLESIZE + 2);
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = (longint'(1) << (BITSIZE - 1)) - 1;
    return BITSIZE'((sum * amp + (longint'(1) << 29)) >>> 30);
  endfunction

  logic [BITSIZE-1:0] w_rom [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic [BITSIZE-1:0] ENTRY = sin_entry(gi);
    assign w_rom[gi] = ENTRY;
  end

  logic                   r_sync1, r_sync2, r_hist;
  logic                   w_frame_start, w_start;
  state_t                 r_state;
  logic [VW-1:0]          r_voice;
  logic                   r_drain;
  logic [PHASESIZE-1:0]   r_stg_freq [NVOICES];
  logic [PHASESIZE-1:0]   r_freq     [NVOICES];
  logic [PHASESIZE-1:0]   r_phase    [NVOICES];
  logic                   r_stg_en   [NVOICES];
  logic                   r_en       [NVOICES];
  logic [TABLESIZE-1:0]   r_idx;
  logic                   r_s0_valid, r_s0_en, r_s0_sign, r_s0_last;
  logic [BITSIZE-1:0]     r_val;
  logic                   r_s1_valid, r_s1_en, r_s1_sign, r_s1_last;
  logic signed [ACCW-1:0] r_acc, w_val_ext, w_term, w_acc_next;
  logic [BITSIZE-1:0]     r_out, w_result;
  logic                   r_out_valid, r_busy, r_overrun;

  assign w_frame_start = r_sync2 & ~r_hist;
  // A start that arrives while a frame is still in flight is dropped.
  assign w_start       = w_frame_start & ~r_busy;

  // Per-voice staging/active configuration and phase accumulators.
  for (genvar gi = 0; gi < NVOICES; gi++) begin : g_voice
    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_stg_freq[gi] <= '0;
        r_stg_en[gi]   <= 1'b0;
        r_freq[gi]     <= '0;
        r_en[gi]       <= 1'b0;
        r_phase[gi]    <= '0;
      end else begin
        if (cfg_we && cfg_addr == VW'(gi)) begin
          r_stg_freq[gi] <= cfg_freq;
          r_stg_en[gi]   <= cfg_en;
        end
        // Copy uses the pre-edge staging value, so a same-cycle write waits a frame.
        if (w_start) begin
          r_freq[gi] <= r_stg_freq[gi];
          r_en[gi]   <= r_stg_en[gi];
        end
        if (r_state == ISSUE && r_voice == VW'(gi) && r_en[gi]) begin
          r_phase[gi] <= r_phase[gi] + r_freq[gi];
        end
      end
    end
  end

  // Registered ROM read; one lookup per cycle at most.
  always_ff @(posedge clk) begin
    r_val <= w_rom[r_idx];
  end

  assign w_val_ext = {{VW{r_val[BITSIZE-1]}}, r_val};

  always_comb begin
    w_term = '0;
    if (r_s1_en) begin
      w_term = r_s1_sign ? -w_val_ext : w_val_ext;
    end
  end

  assign w_acc_next = r_acc + w_term;

`ifdef SINESCHED_SATURATE_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(VW+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(VW+1){1'b1}}, {(BITSIZE-1){1'b0}}};
  always_comb begin
    w_result = w_acc_next[BITSIZE-1:0];
    if (w_acc_next > SAT_MAX) begin
      w_result = SAT_MAX[BITSIZE-1:0];
    end else if (w_acc_next < SAT_MIN) begin
      w_result = SAT_MIN[BITSIZE-1:0];
    end
  end
`else
  assign w_result = BITSIZE'(w_acc_next >>> VW);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_hist      <= 1'b0;
      r_state     <= IDLE;
      r_voice     <= '0;
      r_drain     <= 1'b0;
      r_idx       <= '0;
      r_s0_valid  <= 1'b0;
      r_s0_en     <= 1'b0;
      r_s0_sign   <= 1'b0;
      r_s0_last   <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_en     <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_last   <= 1'b0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1     <= lrclk;
      r_sync2     <= r_sync1;
      r_hist      <= r_sync2;
      r_out_valid <= 1'b0;
      r_s0_valid  <= 1'b0;
      r_s1_valid  <= r_s0_valid;
      r_s1_en     <= r_s0_en;
      r_s1_sign   <= r_s0_sign;
      r_s1_last   <= r_s0_last;

      if (w_frame_start && r_busy) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= ISSUE;
            r_voice <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          // Second quadrant bit mirrors the index; top bit is the output sign.
          r_idx      <= r_phase[r_voice][PHASESIZE-3 -: TABLESIZE]
                        ^ {TABLESIZE{r_phase[r_voice][PHASESIZE-2]}};
          r_s0_sign  <= r_phase[r_voice][PHASESIZE-1];
          r_s0_en    <= r_en[r_voice];
          r_s0_valid <= 1'b1;
          r_s0_last  <= (r_voice == VW'(NVOICES - 1));
          if (r_voice == VW'(NVOICES - 1)) begin
            r_state <= DRAIN;
            r_drain <= 1'b0;
          end else begin
            r_voice <= r_voice + VW'(1);
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_state <= IDLE;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (r_s1_valid) begin
        r_acc <= w_acc_next;
        if (r_s1_last) begin
          r_out       <= w_result;
          r_out_valid <= 1'b1;
        end
      end

      // busy stays up through the out_valid cycle.
      if (r_out_valid) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
`timescale 1ns/1ps
module tb_sine_voice_scheduler;
  localparam int NV  = 4;
  localparam int TOL = 4;

  logic        clk = 1'b0;
  logic        resetn, lrclk, cfg_we, cfg_en;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_freq;
  logic [23:0] out;
  logic        out_valid, busy, overrun;

  sine_voice_scheduler dut (
    .clk(clk), .resetn(resetn), .lrclk(lrclk),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_freq(cfg_freq), .cfg_en(cfg_en),
    .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned m_stg_freq [NV];
  int unsigned m_freq     [NV];
  int unsigned m_phase    [NV];
  bit          m_stg_en   [NV];
  bit          m_en       [NV];
  bit          m_overrun;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input longint obs, input longint exp);
    checks++;
    assert (((obs - exp) <= TOL) && ((exp - obs) <= TOL)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (+/-%0d)", tag, obs, exp, TOL);
    end
  endtask

  // Ideal quarter-sine entry with half-step sample centres.
  function automatic int tbl(input int i);
    real v;
    v = 8388607.0 * $sin(3.14159265358979 * real'(2 * i + 1) / 2048.0);
    return $rtoi(v + 0.5);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_stg_freq[v] = 0; m_freq[v] = 0; m_phase[v] = 0;
      m_stg_en[v] = 1'b0; m_en[v] = 1'b0;
    end
    m_overrun = 1'b0;
  endtask

  // One accepted frame: latch config, sum the enabled voices, advance phases.
  function automatic longint model_frame();
    longint sum;
    int idx, val;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      m_freq[v] = m_stg_freq[v];
      m_en[v]   = m_stg_en[v];
    end
    for (int v = 0; v < NV; v++) begin
      if (m_en[v]) begin
        idx = int'((m_phase[v] / 32) % 512);
        if (((m_phase[v] / 16384) % 2) == 1) idx = 511 - idx;
        val = tbl(idx);
        sum += (m_phase[v] >= 32768) ? -val : val;
        m_phase[v] = (m_phase[v] + m_freq[v]) % 65536;
      end
    end
`ifdef SINESCHED_SATURATE_EN
    if (sum > 8388607) sum = 8388607;
    else if (sum < -8388608) sum = -8388608;
    return sum;
`else
    return sum >>> 2;
`endif
  endfunction

  task automatic cfg_write(input int a, input int f, input bit e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_freq = 16'(f); cfg_en = e;
    @(negedge clk);
    cfg_we = 1'b0;
    m_stg_freq[a] = f;
    m_stg_en[a]   = e;
    $display("cfg   voice=%0d freq=0x%04h en=%0d", a, f, e);
  endtask

  // Raise lrclk and watch 16 cycles. Optional second rise detected 4 cycles
  // after frame start (glitch) and optional write in the frame-start cycle.
  task automatic run_frame(input string tag, input bit glitch, input bit coll,
                           input int caddr, input int cfreq, input bit cen);
    longint exp, got;
    int nvalid, first_valid, nbusy, first_busy;
    exp = model_frame();
    if (coll) begin
      m_stg_freq[caddr] = cfreq;
      m_stg_en[caddr]   = cen;
    end
    if (glitch) m_overrun = 1'b1;
    nvalid = 0; first_valid = -1; nbusy = 0; first_busy = -1; got = 0;
    @(posedge clk);
    #1 lrclk = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        nvalid++;
        if (first_valid < 0) first_valid = c;
        got = longint'($signed(out));
      end
      if (busy) begin
        nbusy++;
        if (first_busy < 0) first_busy = c;
      end
      if (coll && c == 2) begin
        cfg_we = 1'b1; cfg_addr = 2'(caddr); cfg_freq = 16'(cfreq); cfg_en = cen;
      end
      if (coll && c == 3) cfg_we = 1'b0;
      if (glitch && c == 2) lrclk = 1'b0;
      if (glitch && c == 4) lrclk = 1'b1;
      if (c == 8) lrclk = 1'b0;
    end
    $display("frame %s out=%0d expected=%0d valids=%0d busy_cycles=%0d overrun=%0d",
             tag, got, exp, nvalid, nbusy, overrun);
    chk({tag, ".nvalid"}, nvalid, 1);
    chk({tag, ".valid_cycle"}, first_valid, 9);
    chk({tag, ".busy_cycles"}, nbusy, 7);
    chk({tag, ".busy_start"}, first_busy, 3);
    chk_near({tag, ".out"}, got, exp);
    chk({tag, ".overrun"}, longint'(overrun), longint'(m_overrun));
  endtask

  task automatic reset_mid_frame();
    int nvalid;
    nvalid = 0;
    @(posedge clk);
    #1 lrclk = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) nvalid++;
    end
    resetn = 1'b0;
    lrclk  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("midreset.busy", longint'(busy), 0);
    chk("midreset.out", longint'(out), 0);
    chk("midreset.overrun", longint'(overrun), 0);
    resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    $display("reset mid-frame valids=%0d", nvalid);
    chk("midreset.nvalid", nvalid, 0);
    model_reset();
  endtask

  initial begin
    resetn = 1'b0; lrclk = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_freq = '0; cfg_en = 1'b0;
    model_reset();

    // Reset with lrclk toggling
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset.out", longint'(out), 0);
      chk("reset.out_valid", longint'(out_valid), 0);
      chk("reset.busy", longint'(busy), 0);
      chk("reset.overrun", longint'(overrun), 0);
      lrclk = ~lrclk;
    end
    @(negedge clk);
    lrclk  = 1'b0;
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // Single voice, quarter-wave steps
    cfg_write(0, 'h4000, 1'b1);
    for (int f = 0; f < 4; f++) run_frame($sformatf("quarter%0d", f), 1'b0, 1'b0, 0, 0, 1'b0);

    // Full mix (clamps in the saturating build)
    for (int v = 1; v < NV; v++) cfg_write(v, 'h4000, 1'b1);
    for (int f = 0; f < 2; f++) run_frame($sformatf("mix%0d", f), 1'b0, 1'b0, 0, 0, 1'b0);

    // Write colliding with frame start
    run_frame("collide", 1'b0, 1'b1, 1, 'h1000, 1'b1);
    run_frame("collide_next", 1'b0, 1'b0, 0, 0, 1'b0);

    // Overrun: second start 4 cycles after E
    run_frame("overrun", 1'b1, 1'b0, 0, 0, 1'b0);
    run_frame("after_overrun", 1'b0, 1'b0, 0, 0, 1'b0);

    // Wrap and hold on voice 2
    cfg_write(0, 'h4000, 1'b0);
    cfg_write(1, 'h1000, 1'b0);
    cfg_write(3, 'h4000, 1'b0);
    cfg_write(2, 'hFFFF, 1'b1);
    for (int f = 0; f < 3; f++) run_frame($sformatf("wrap%0d", f), 1'b0, 1'b0, 0, 0, 1'b0);
    cfg_write(2, 'hFFFF, 1'b0);
    for (int f = 0; f < 3; f++) run_frame($sformatf("hold%0d", f), 1'b0, 1'b0, 0, 0, 1'b0);
    cfg_write(2, 'h0800, 1'b1);
    run_frame("resume", 1'b0, 1'b0, 0, 0, 1'b0);

    // Randomized configurations
    for (int r = 0; r < 8; r++) begin
      cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)), 1'($urandom_range(0, 3) != 0));
      run_frame($sformatf("rand%0d", r), 1'b0, ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)), 1'b1);
    end

    // Reset in the middle of a frame, then a clean frame
    reset_mid_frame();
    cfg_write(3, int'($urandom_range(1, 65535)), 1'b1);
    run_frame("post_reset0", 1'b0, 1'b0, 0, 0, 1'b0);
    run_frame("post_reset1", 1'b0, 1'b0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
